fft_sweep_ctrl: RTL and testbench
=================================

Name: fft_sweep_ctrl

Overview:
- Sequences a stepped frequency sweep of the down-conversion front end.
- For each step, the block loads the step value into the down-converter, waits for it to settle, and runs a fixed number of FFT detect frames. It then records whether any frame flagged a hit and advances to the next step.
- Sits between the control/UART layer and the FFT-detect/down-converter pair. It gates FFT triggering so frames are never taken during re-tuning.

Parameters:
- STEP_MIN, 0, first step value (7-bit).
- STEP_MAX, 127, last step value allowed (7-bit).
- STEP_INC, 1, step increment, 1..127.
- FRAMES_PER_STEP, 4, detect frames per step, 1..255.
- SETTLE_CYCLES, 256, wait after ready before frames start, 1..65535.
- TIMEOUT_CYCLES, 1000000, max cycles between frame ends in RUN (32-bit counter).

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- s_sweep_start  in  1  pulse; begin sweep (ignored while busy)
- s_sweep_abort  in  1  pulse; abandon sweep
- m_convert_config_step  out  7  step value to down-converter
- m_convert_config_valid  out  1  one-cycle load strobe
- s_convert_config_ready  in  1  down-converter settled/loaded (level)
- s_frame_end  in  1  detect frame-end level; rising edge = frame complete
- s_frame_hit  in  1  detect hit flag, sampled on frame-end edge
- m_fft_enable  out  1  permits FFT triggering (level)
- m_sweep_busy  out  1  high in any state except IDLE
- m_hit_valid  out  1  one-cycle pulse: current step had a hit
- m_hit_step  out  7  step reported with m_hit_valid
- m_sweep_done  out  1  one-cycle pulse at sweep completion
- m_err_timeout  out  1  sticky; set on frame timeout, cleared by start or reset

Behaviour:

Reset values:
- All outputs 0, except m_convert_config_step = STEP_MIN.
- State IDLE; all counters 0.

States and transitions:
- IDLE: on s_sweep_start, load step=STEP_MIN, frame_cnt=0, hit_acc=0, clear m_err_timeout → CONFIG.
- CONFIG: m_convert_config_valid=1 for exactly this cycle, with m_convert_config_step already holding the new value → SETTLE.
- SETTLE: wait until s_convert_config_ready=1, then count SETTLE_CYCLES. On expiry: clear timeout counter, set frame-end edge register to the current s_frame_end (no false edge) → RUN.
- RUN:
  - m_fft_enable=1.
  - Frame event = s_frame_end rising edge (registered previous value).
  - On a frame event: hit_acc |= s_frame_hit; frame_cnt++; timeout counter cleared.
  - Timeout counter reaching TIMEOUT_CYCLES-1 is also a frame event, with hit treated as 0, and sets m_err_timeout.
  - When the frame event with frame_cnt == FRAMES_PER_STEP-1 occurs → NEXT.
- NEXT (1 cycle):
  - m_fft_enable=0.
  - If hit_acc, pulse m_hit_valid with m_hit_step = step.
  - Clear hit_acc and frame_cnt.
  - If step+STEP_INC > STEP_MAX (computed in 8 bits, no wrap) → DONE; else step += STEP_INC → CONFIG.
- DONE (1 cycle): pulse m_sweep_done → IDLE.

Timing:
- m_fft_enable deasserts the cycle RUN is left. It is 0 in CONFIG/SETTLE/NEXT/DONE/IDLE.
- Minimum latency: start → first config strobe is 1 cycle.

Boundary conditions:
- s_sweep_abort in any non-IDLE state → IDLE next cycle. m_fft_enable=0, no hit or done pulses that cycle; step retains its last value.
- Abort takes priority over every simultaneous event.
- Start while busy is ignored. Start and abort together in IDLE: abort wins, stay IDLE.
- s_convert_config_ready dropping during the settle count restarts the count.
- Frame edges outside RUN are ignored.
- STEP_MIN > STEP_MAX: sweep runs the single step STEP_MIN, then DONE.
- Reset mid-sweep: immediate return to reset values, no pulses.

Optional Feature:
- Macro FFT_SWEEP_CONTINUOUS_EN.
- Defined: DONE pulses m_sweep_done, then goes directly to CONFIG with step=STEP_MIN (endless sweep until abort). m_sweep_busy stays 1; m_err_timeout is not cleared on auto-restart.
- Undefined: DONE → IDLE as specified above.

Test Plan:
- STEP_MIN=0, STEP_MAX=3, FRAMES_PER_STEP=2, ready tied 1, frame edges every 100 cycles, no hits → 4 config strobes with steps 0,1,2,3; 8 frames counted; one m_sweep_done; no m_hit_valid.
- Same setup, s_frame_hit=1 only on the 2nd frame of step 2 → exactly one m_hit_valid with m_hit_step=2.
- Abort asserted in RUN during step 1 → next cycle m_sweep_busy=0 and m_fft_enable=0; no done pulse; a subsequent start begins again at step 0.
- No frame edges, TIMEOUT_CYCLES=50, FRAMES_PER_STEP=1, STEP_MAX=0 → m_err_timeout=1 after 50 RUN cycles, sweep completes with done, no hit.
- s_convert_config_ready held 0 for 500 cycles, then 1 → m_fft_enable rises exactly SETTLE_CYCLES+1 cycles after ready rises; s_frame_end already high at RUN entry produces no frame count.
- STEP_INC=100, STEP_MIN=20, STEP_MAX=127 → steps 20 and 120 only, then done (no 7-bit wrap to 92).

Source files
------------

// File: rtl/fft_sweep_ctrl.sv
// Stepped down-converter sweep controller: tune, settle, run N FFT detect frames, report hits.
// Build option FFT_SWEEP_CONTINUOUS_EN restarts from STEP_MIN after every sweep until aborted.
//   state  | meaning
//   IDLE   | waiting for start
//   CONFIG | load strobe to down-converter
//   SETTLE | wait for ready, then settle count
//   RUN    | FFT enabled, counting frames
//   NEXT   | report hit, advance step
//   DONE   | sweep complete pulse
module fft_sweep_ctrl #(
    parameter int unsigned STEP_MIN        = 0,
    parameter int unsigned STEP_MAX        = 127,
    parameter int unsigned STEP_INC        = 1,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned SETTLE_CYCLES   = 256,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       s_sweep_start,
    input  logic       s_sweep_abort,
    output logic [6:0] m_convert_config_step,
    output logic       m_convert_config_valid,
    input  logic       s_convert_config_ready,
    input  logic       s_frame_end,
    input  logic       s_frame_hit,
    output logic       m_fft_enable,
    output logic       m_sweep_busy,
    output logic       m_hit_valid,
    output logic [6:0] m_hit_step,
    output logic       m_sweep_done,
    output logic       m_err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_SETTLE, S_RUN, S_NEXT, S_DONE
    } state_t;

    localparam logic [6:0]  LP_STEP_MIN     = 7'(STEP_MIN);
    localparam logic [7:0]  LP_STEP_MAX     = 8'(STEP_MAX);
    localparam logic [7:0]  LP_STEP_INC     = 8'(STEP_INC);
    localparam logic [7:0]  LP_FRAME_LAST   = 8'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] LP_SETTLE       = 16'(SETTLE_CYCLES);
    localparam logic [31:0] LP_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [6:0]  r_step;
    logic [7:0]  r_frame_cnt;
    logic        r_hit_acc;
    logic [15:0] r_settle_cnt;
    logic [31:0] r_to_cnt;
    logic        r_frame_prev;
    logic        r_cfg_valid;
    logic        r_fft_en;
    logic        r_busy;
    logic        r_hit_valid;
    logic [6:0]  r_hit_step;
    logic        r_done;
    logic        r_err;

    logic       w_frame_edge;
    logic       w_to_expired;
    logic       w_frame_evt;
    logic       w_hit_in;
    logic [7:0] w_step_sum;

    // A real frame edge wins over a coincident timeout; the timeout only fills in a missing frame.
    assign w_frame_edge = s_frame_end & ~r_frame_prev;
    assign w_to_expired = (r_to_cnt == 32'd0);
    assign w_frame_evt  = w_frame_edge | w_to_expired;
    assign w_hit_in     = w_frame_edge & s_frame_hit;
    assign w_step_sum   = {1'b0, r_step} + LP_STEP_INC;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_step       <= LP_STEP_MIN;
            r_frame_cnt  <= 8'd0;
            r_hit_acc    <= 1'b0;
            r_settle_cnt <= 16'd0;
            r_to_cnt     <= 32'd0;
            r_frame_prev <= 1'b0;
            r_cfg_valid  <= 1'b0;
            r_fft_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_hit_valid  <= 1'b0;
            r_hit_step   <= 7'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_prev <= s_frame_end;
            r_cfg_valid  <= 1'b0;
            r_hit_valid  <= 1'b0;
            r_done       <= 1'b0;
            if (s_sweep_abort && (r_state != S_IDLE)) begin
                r_state  <= S_IDLE;
                r_fft_en <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (s_sweep_start && !s_sweep_abort) begin
                            r_step      <= LP_STEP_MIN;
                            r_frame_cnt <= 8'd0;
                            r_hit_acc   <= 1'b0;
                            r_err       <= 1'b0;
                            r_cfg_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_CONFIG;
                        end
                    end
                    S_CONFIG: begin
                        r_settle_cnt <= LP_SETTLE;
                        r_state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (!s_convert_config_ready) begin
                            r_settle_cnt <= LP_SETTLE;
                        end else if (r_settle_cnt == 16'd0) begin
                            r_to_cnt <= LP_TIMEOUT_LAST;
                            r_fft_en <= 1'b1;
                            r_state  <= S_RUN;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (w_frame_evt) begin
                            r_to_cnt <= LP_TIMEOUT_LAST;
                            if (!w_frame_edge) begin
                                r_err <= 1'b1;
                            end
                            if (r_frame_cnt == LP_FRAME_LAST) begin
                                r_fft_en    <= 1'b0;
                                r_hit_valid <= r_hit_acc | w_hit_in;
                                r_hit_step  <= r_step;
                                r_state     <= S_NEXT;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 8'd1;
                                r_hit_acc   <= r_hit_acc | w_hit_in;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt - 32'd1;
                        end
                    end
                    S_NEXT: begin
                        r_frame_cnt <= 8'd0;
                        r_hit_acc   <= 1'b0;
                        if (w_step_sum > LP_STEP_MAX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_step      <= w_step_sum[6:0];
                            r_cfg_valid <= 1'b1;
                            r_state     <= S_CONFIG;
                        end
                    end
                    S_DONE: begin
`ifdef FFT_SWEEP_CONTINUOUS_EN
                        r_step      <= LP_STEP_MIN;
                        r_cfg_valid <= 1'b1;
                        r_state     <= S_CONFIG;
`else
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end
                    default: begin
                        r_fft_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign m_convert_config_step  = r_step;
    assign m_convert_config_valid = r_cfg_valid;
    assign m_fft_enable           = r_fft_en;
    assign m_sweep_busy           = r_busy;
    assign m_hit_valid            = r_hit_valid;
    assign m_hit_step             = r_hit_step;
    assign m_sweep_done           = r_done;
    assign m_err_timeout          = r_err;

endmodule

// File: tb/tb_fft_sweep_ctrl.sv
// Self-checking bench for fft_sweep_ctrl: three differently parameterised instances
// driven one at a time, checked against a step/hit model computed from the sweep rules.
module tb_fft_sweep_ctrl;

    localparam int A_MIN = 0,  A_MAX = 3,   A_INC = 1,   A_F = 2, A_S = 16, A_T = 1000;
    localparam int B_MIN = 9,  B_MAX = 0,   B_INC = 1,   B_F = 1, B_S = 4,  B_T = 50;
    localparam int C_MIN = 20, C_MAX = 127, C_INC = 100, C_F = 1, C_S = 2,  C_T = 1000;

    logic clk = 1'b0;
    logic rst;
    logic start [3];
    logic abort [3];
    logic ready [3];
    logic fend  [3];
    logic fhit  [3];
    logic cv    [3];
    logic en    [3];
    logic busy  [3];
    logic hv    [3];
    logic dn    [3];
    logic err   [3];
    logic [6:0] cstep [3];
    logic [6:0] hstep [3];

    int n_checks;
    int n_fail;
    int cur;
    int n_done;
    bit tmo;
    logic [6:0] q_cfg [$];
    logic [6:0] q_hit [$];
    int exp_steps [$];
    int exp_hits  [$];
    bit hits [16][8];

    always #5 clk = ~clk;

    fft_sweep_ctrl #(.STEP_MIN(A_MIN), .STEP_MAX(A_MAX), .STEP_INC(A_INC),
                     .FRAMES_PER_STEP(A_F), .SETTLE_CYCLES(A_S), .TIMEOUT_CYCLES(A_T)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .s_sweep_start(start[0]), .s_sweep_abort(abort[0]),
        .m_convert_config_step(cstep[0]), .m_convert_config_valid(cv[0]),
        .s_convert_config_ready(ready[0]), .s_frame_end(fend[0]), .s_frame_hit(fhit[0]),
        .m_fft_enable(en[0]), .m_sweep_busy(busy[0]), .m_hit_valid(hv[0]), .m_hit_step(hstep[0]),
        .m_sweep_done(dn[0]), .m_err_timeout(err[0]));

    fft_sweep_ctrl #(.STEP_MIN(B_MIN), .STEP_MAX(B_MAX), .STEP_INC(B_INC),
                     .FRAMES_PER_STEP(B_F), .SETTLE_CYCLES(B_S), .TIMEOUT_CYCLES(B_T)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .s_sweep_start(start[1]), .s_sweep_abort(abort[1]),
        .m_convert_config_step(cstep[1]), .m_convert_config_valid(cv[1]),
        .s_convert_config_ready(ready[1]), .s_frame_end(fend[1]), .s_frame_hit(fhit[1]),
        .m_fft_enable(en[1]), .m_sweep_busy(busy[1]), .m_hit_valid(hv[1]), .m_hit_step(hstep[1]),
        .m_sweep_done(dn[1]), .m_err_timeout(err[1]));

    fft_sweep_ctrl #(.STEP_MIN(C_MIN), .STEP_MAX(C_MAX), .STEP_INC(C_INC),
                     .FRAMES_PER_STEP(C_F), .SETTLE_CYCLES(C_S), .TIMEOUT_CYCLES(C_T)) u_dut_c (
        .sys_clk(clk), .sys_rst(rst), .s_sweep_start(start[2]), .s_sweep_abort(abort[2]),
        .m_convert_config_step(cstep[2]), .m_convert_config_valid(cv[2]),
        .s_convert_config_ready(ready[2]), .s_frame_end(fend[2]), .s_frame_hit(fhit[2]),
        .m_fft_enable(en[2]), .m_sweep_busy(busy[2]), .m_hit_valid(hv[2]), .m_hit_step(hstep[2]),
        .m_sweep_done(dn[2]), .m_err_timeout(err[2]));

    always @(negedge clk) begin
        if (cv[cur] === 1'b1) q_cfg.push_back(cstep[cur]);
        if (hv[cur] === 1'b1) q_hit.push_back(hstep[cur]);
        if (dn[cur] === 1'b1) n_done++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic int p_min(input int d);
        case (d) 0: return A_MIN; 1: return B_MIN; default: return C_MIN; endcase
    endfunction
    function automatic int p_max(input int d);
        case (d) 0: return A_MAX; 1: return B_MAX; default: return C_MAX; endcase
    endfunction
    function automatic int p_inc(input int d);
        case (d) 0: return A_INC; 1: return B_INC; default: return C_INC; endcase
    endfunction
    function automatic int p_f(input int d);
        case (d) 0: return A_F; 1: return B_F; default: return C_F; endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs(input int d);
        cur = d;
        q_cfg.delete();
        q_hit.delete();
        n_done = 0;
    endtask

    // Reference model: visited steps and hit-reporting steps, from the sweep arithmetic.
    task automatic build_model(input int d);
        int s;
        bit any;
        exp_steps.delete();
        exp_hits.delete();
        s = p_min(d);
        for (int g = 0; g < 16; g++) begin
            exp_steps.push_back(s);
            if (s + p_inc(d) > p_max(d)) break;
            s = s + p_inc(d);
        end
        for (int k = 0; k < exp_steps.size(); k++) begin
            any = 0;
            for (int j = 0; j < p_f(d); j++) any = any | hits[k][j];
            if (any) exp_hits.push_back(exp_steps[k]);
        end
    endtask

    task automatic run_sweep(input int d, input bit inj);
        int w;
        tmo = 0;
        clear_obs(d);
        start[d] = 1'b1; tick(); start[d] = 1'b0;
        for (int k = 0; k < exp_steps.size(); k++) begin
            w = 0;
            while (en[d] !== 1'b1 && w < 3000) begin tick(); w++; end
            if (w >= 3000) tmo = 1;
            for (int j = 0; j < p_f(d); j++) begin
                if (inj && k == 1 && j == 0) begin
                    start[d] = 1'b1; tick(); start[d] = 1'b0;
                end
                repeat ($urandom_range(3, 30)) tick();
                fend[d] = 1'b1; fhit[d] = hits[k][j]; tick();
                fhit[d] = 1'b0; tick();
                fend[d] = 1'b0;
            end
            w = 0;
            while (en[d] !== 1'b0 && w < 10) begin tick(); w++; end
            if (w >= 10) tmo = 1;
        end
        w = 0;
        while (n_done == 0 && w < 50) begin tick(); w++; end
        if (n_done == 0) tmo = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < 3; d++) begin
                n_checks += 8;
                if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
                if (en[d] !== 1'b0) begin n_fail++; $display("FAIL reset_fft_en[%0d]: got %b want 0", d, en[d]); end
                if (cv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid[%0d]: got %b want 0", d, cv[d]); end
                if (hv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_hit_valid[%0d]: got %b want 0", d, hv[d]); end
                if (dn[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", d, dn[d]); end
                if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
                if (cstep[d] !== 7'(p_min(d))) begin n_fail++; $display("FAIL reset_step[%0d]: got %0d want %0d", d, cstep[d], p_min(d)); end
                if (hstep[d] !== 7'd0) begin n_fail++; $display("FAIL reset_hit_step[%0d]: got %0d want 0", d, hstep[d]); end
            end
            rst = 1'b0;
            tick();
        end
    endtask

    // mode 0: no hits, 1: hit only on 2nd frame of step 2, 2: random hits
    task automatic test_sweep(input int mode, input bit inj);
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 8; j++)
                hits[k][j] = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (mode == 1) hits[2][1] = 1'b1;
        build_model(0);
        run_sweep(0, inj);
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL sweep_bound(mode %0d): wait expired, got %b want 0", mode, tmo); end
        n_checks++;
        if (q_cfg.size() !== exp_steps.size()) begin n_fail++; $display("FAIL sweep_cfg_count(mode %0d): got %0d want %0d", mode, q_cfg.size(), exp_steps.size()); end
        for (int i = 0; i < q_cfg.size() && i < exp_steps.size(); i++) begin
            n_checks++;
            if (q_cfg[i] !== 7'(exp_steps[i])) begin n_fail++; $display("FAIL sweep_cfg_step[%0d](mode %0d): got %0d want %0d", i, mode, q_cfg[i], exp_steps[i]); end
        end
        n_checks++;
        if (q_hit.size() !== exp_hits.size()) begin n_fail++; $display("FAIL sweep_hit_count(mode %0d): got %0d want %0d", mode, q_hit.size(), exp_hits.size()); end
        for (int i = 0; i < q_hit.size() && i < exp_hits.size(); i++) begin
            n_checks++;
            if (q_hit[i] !== 7'(exp_hits[i])) begin n_fail++; $display("FAIL sweep_hit_step[%0d](mode %0d): got %0d want %0d", i, mode, q_hit[i], exp_hits[i]); end
        end
        n_checks += 3;
        if (n_done !== 1) begin n_fail++; $display("FAIL sweep_done(mode %0d): got %0d pulses want 1", mode, n_done); end
        if (err[0] !== 1'b0) begin n_fail++; $display("FAIL sweep_err(mode %0d): got %b want 0", mode, err[0]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_end(mode %0d): got %b want 0", mode, busy[0]); end
    endtask

    task automatic test_abort();
        int w;
        clear_obs(0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        n_checks += 2;
        if (cv[0] !== 1'b1) begin n_fail++; $display("FAIL start_latency_valid: got %b want 1", cv[0]); end
        if (cstep[0] !== 7'd0) begin n_fail++; $display("FAIL start_latency_step: got %0d want 0", cstep[0]); end
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (en[0] !== 1'b1 && w < 200) begin tick(); w++; end
            n_checks++;
            if (w >= 200) begin n_fail++; $display("FAIL abort_wait_run%0d: waited %0d cycles want <200", k, w); end
            if (k == 0) begin
                for (int j = 0; j < 2; j++) begin
                    repeat (5) tick();
                    fend[0] = 1'b1; tick(); tick(); fend[0] = 1'b0;
                end
            end
        end
        n_checks++;
        if (cstep[0] !== 7'd1) begin n_fail++; $display("FAIL abort_in_step1: got %0d want 1", cstep[0]); end
        repeat (4) tick();
        abort[0] = 1'b1; fend[0] = 1'b1; fhit[0] = 1'b1; tick();
        abort[0] = 1'b0; fend[0] = 1'b0; fhit[0] = 1'b0;
        n_checks += 4;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
        if (en[0] !== 1'b0) begin n_fail++; $display("FAIL abort_fft_en: got %b want 0", en[0]); end
        if (cstep[0] !== 7'd1) begin n_fail++; $display("FAIL abort_step_kept: got %0d want 1", cstep[0]); end
        if (hv[0] !== 1'b0) begin n_fail++; $display("FAIL abort_hit: got %b want 0", hv[0]); end
        repeat (20) tick();
        n_checks += 2;
        if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        if (q_hit.size() !== 0) begin n_fail++; $display("FAIL abort_no_hit: got %0d want 0", q_hit.size()); end
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        n_checks += 2;
        if (cv[0] !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b want 1", cv[0]); end
        if (cstep[0] !== 7'd0) begin n_fail++; $display("FAIL restart_step: got %0d want 0", cstep[0]); end
        abort[0] = 1'b1; tick(); abort[0] = 1'b0;
        tick();
        start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
        n_checks += 2;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle_busy: got %b want 0", busy[0]); end
        if (cv[0] !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle_valid: got %b want 0", cv[0]); end
        tick();
    endtask

    task automatic test_timeout();
        int w;
        int n;
        clear_obs(1);
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        w = 0;
        while (en[1] !== 1'b1 && w < 100) begin tick(); w++; end
        n_checks++;
        if (w >= 100) begin n_fail++; $display("FAIL timeout_wait_run: waited %0d cycles want <100", w); end
        n = 0;
        while (err[1] !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks += 2;
        if (n !== B_T) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, B_T); end
        if (en[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_fft_en: got %b want 0", en[1]); end
        w = 0;
        while (n_done == 0 && w < 10) begin tick(); w++; end
        repeat (3) tick();
        n_checks += 5;
        if (n_done !== 1) begin n_fail++; $display("FAIL timeout_done: got %0d want 1", n_done); end
        if (q_hit.size() !== 0) begin n_fail++; $display("FAIL timeout_no_hit: got %0d want 0", q_hit.size()); end
        if (q_cfg.size() !== 1) begin n_fail++; $display("FAIL timeout_cfg_count: got %0d want 1", q_cfg.size()); end
        if (err[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", err[1]); end
        if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_end: got %b want 0", busy[1]); end
        if (q_cfg.size() > 0) begin
            n_checks++;
            if (q_cfg[0] !== 7'(B_MIN)) begin n_fail++; $display("FAIL single_step_min_gt_max: got %0d want %0d", q_cfg[0], B_MIN); end
        end
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        n_checks++;
        if (err[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_clear_on_start: got %b want 0", err[1]); end
        abort[1] = 1'b1; tick(); abort[1] = 1'b0;
        tick();
    endtask

    task automatic test_settle();
        int n;
        bit saw_en;
        clear_obs(0);
        ready[0] = 1'b0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        saw_en = 0;
        for (int i = 0; i < 500; i++) begin
            fend[0] = ((i % 7) < 3);
            tick();
            if (en[0] !== 1'b0) saw_en = 1;
        end
        n_checks += 2;
        if (saw_en !== 1'b0) begin n_fail++; $display("FAIL settle_no_ready_en: got %b want 0", saw_en); end
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL settle_busy: got %b want 1", busy[0]); end
        fend[0] = 1'b1;
        ready[0] = 1'b1; repeat (10) tick();
        ready[0] = 1'b0; repeat (3) tick();
        ready[0] = 1'b1;
        n = 0;
        while (en[0] !== 1'b1 && n < 100) begin tick(); n++; end
        n_checks++;
        if (n !== A_S + 1) begin n_fail++; $display("FAIL settle_latency: got %0d want %0d", n, A_S + 1); end
        repeat (20) tick();
        fend[0] = 1'b0; tick(); tick();
        fend[0] = 1'b1; tick(); tick();
        n_checks++;
        if (en[0] !== 1'b1) begin n_fail++; $display("FAIL settle_no_false_edge: got %b want 1", en[0]); end
        fend[0] = 1'b0; tick(); tick();
        fend[0] = 1'b1; tick(); tick();
        n_checks++;
        if (en[0] !== 1'b0) begin n_fail++; $display("FAIL settle_second_frame_ends_step: got %b want 0", en[0]); end
        fend[0] = 1'b0;
        abort[0] = 1'b1; tick(); abort[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL settle_abort_busy: got %b want 0", busy[0]); end
        tick();
    endtask

    task automatic test_wide_inc();
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 8; j++)
                hits[k][j] = ($urandom_range(0, 1) == 1);
        build_model(2);
        run_sweep(2, 1'b0);
        n_checks += 3;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL wide_bound: wait expired, got %b want 0", tmo); end
        if (q_cfg.size() !== exp_steps.size()) begin n_fail++; $display("FAIL wide_cfg_count: got %0d want %0d", q_cfg.size(), exp_steps.size()); end
        if (q_hit.size() !== exp_hits.size()) begin n_fail++; $display("FAIL wide_hit_count: got %0d want %0d", q_hit.size(), exp_hits.size()); end
        for (int i = 0; i < q_cfg.size() && i < exp_steps.size(); i++) begin
            n_checks++;
            if (q_cfg[i] !== 7'(exp_steps[i])) begin n_fail++; $display("FAIL wide_cfg_step[%0d]: got %0d want %0d", i, q_cfg[i], exp_steps[i]); end
        end
        for (int i = 0; i < q_hit.size() && i < exp_hits.size(); i++) begin
            n_checks++;
            if (q_hit[i] !== 7'(exp_hits[i])) begin n_fail++; $display("FAIL wide_hit_step[%0d]: got %0d want %0d", i, q_hit[i], exp_hits[i]); end
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL wide_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid();
        int w;
        clear_obs(0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (en[0] !== 1'b1 && w < 200) begin tick(); w++; end
            n_checks++;
            if (w >= 200) begin n_fail++; $display("FAIL rstmid_wait_run%0d: waited %0d want <200", k, w); end
            if (k == 0) begin
                for (int j = 0; j < 2; j++) begin
                    repeat (4) tick();
                    fend[0] = 1'b1; fhit[0] = 1'b1; tick(); fhit[0] = 1'b0; tick(); fend[0] = 1'b0;
                end
            end
        end
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_obs(0);
        n_checks += 5;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
        if (en[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_fft_en: got %b want 0", en[0]); end
        if (cstep[0] !== 7'(A_MIN)) begin n_fail++; $display("FAIL rstmid_step: got %0d want %0d", cstep[0], A_MIN); end
        if (hstep[0] !== 7'd0) begin n_fail++; $display("FAIL rstmid_hit_step: got %0d want 0", hstep[0]); end
        if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err[0]); end
        repeat (10) tick();
        n_checks += 3;
        if (n_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
        if (q_hit.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_hit: got %0d want 0", q_hit.size()); end
        if (q_cfg.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_cfg: got %0d want 0", q_cfg.size()); end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; abort[d] = 1'b0; ready[d] = 1'b1;
            fend[d] = 1'b0; fhit[d] = 1'b0;
        end
        cur = 0; n_done = 0; tmo = 0;
        n_checks = 0; n_fail = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sweep(0, 1'b0);
        test_sweep(1, 1'b0);
        test_sweep(2, 1'b1);
        test_sweep(2, 1'b0);
        test_abort();
        test_timeout();
        test_settle();
        test_wide_inc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
